// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller:
// FSM state encoding and the iteration-counter width helper.
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One extra bit so the counter can reach Nbit without wrapping.
    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/adder_carry_n.sv
// Combinational N-bit adder with carry-in and carry-out; the single adder
// the multiplier controller reuses on every iteration.
module adder_carry_n #(
    parameter int Nbit = 8
) (
    input  logic [Nbit-1:0] A,
    input  logic [Nbit-1:0] B,
    input  logic            CI,
    output logic [Nbit-1:0] SUM,
    output logic            CO
);

    assign {CO, SUM} = {1'b0, A} + {1'b0, B} + {{Nbit{1'b0}}, CI};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned Nbit x Nbit multiplier: one shift-add iteration per clock
// through a shared adder, START/DONE handshake, product held until next completion.
module shift_add_mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int Nbit = 8
) (
    input  logic              C,
    input  logic              CLR,
    input  logic              START,
    input  logic [Nbit-1:0]   A,
    input  logic [Nbit-1:0]   B,
    output logic              BUSY,
    output logic              DONE,
    output logic [2*Nbit-1:0] P
);

    localparam int CW = count_width(Nbit);

    state_t            state;
    state_t            state_next;
    logic [Nbit-1:0]   mcand;
    logic [Nbit-1:0]   acc_hi;
    logic [Nbit-1:0]   acc_lo;
    logic [CW-1:0]     count;
    logic [2*Nbit-1:0] prod;

    logic [Nbit-1:0]   addend;
    logic [Nbit-1:0]   sum;
    logic              carry;
    logic              accept;
    logic              last_iter;

    assign addend    = acc_lo[0] ? mcand : '0;
    assign accept    = START && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_iter = (state == ST_RUN) && (count == CW'(Nbit - 1));

    adder_carry_n #(.Nbit(Nbit)) u_adder (
        .A   (acc_hi),
        .B   (addend),
        .CI  (1'b0),
        .SUM (sum),
        .CO  (carry)
    );

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_IDLE: state_next = accept ? ST_RUN : ST_IDLE;
            ST_RUN:  state_next = last_iter ? ST_DONE : ST_RUN;
            ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, otherwise shift the (2*Nbit+1)-bit {carry, sum, acc_lo} right by one.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
            prod   <= '0;
        end else if (accept) begin
            mcand  <= A;
            acc_lo <= B;
            acc_hi <= '0;
            count  <= '0;
        end else if (state == ST_RUN) begin
            acc_hi <= {carry, sum[Nbit-1:1]};
            acc_lo <= {sum[0], acc_lo[Nbit-1:1]};
            count  <= count + CW'(1);
            if (last_iter) prod <= {carry, sum, acc_lo[Nbit-1:1]};
        end
    end

    assign BUSY = (state == ST_RUN);
    assign DONE = (state == ST_DONE);
    assign P    = prod;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed, table-driven bench for shift_add_mult_ctrl (Nbit=8 and Nbit=4 instances).
module tb_shift_add_mult_ctrl;

    logic        clk;
    logic        clr;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  p4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] vp;
    } vec_t;

    vec_t vecs[8];

    shift_add_mult_ctrl #(.Nbit(8)) dut (
        .C(clk), .CLR(clr), .START(start), .A(a), .B(b),
        .BUSY(busy), .DONE(done), .P(p)
    );

    shift_add_mult_ctrl #(.Nbit(4)) dut4 (
        .C(clk), .CLR(clr), .START(start4), .A(a4), .B(b4),
        .BUSY(busy4), .DONE(done4), .P(p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one START pulse, then count cycles until DONE (bounded).
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vp);
        int cycles;
        int busy_cycles;
        a = va;
        b = vb;
        start = 1'b1;
        step();
        start = 1'b0;
        cycles = 0;
        busy_cycles = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cycles++;
            cycles++;
            step();
        end
        check("latency", cycles, 8);
        check("busy_cycles", busy_cycles, 8);
        check("product", p, vp);
        step();
        check("done_pulse_end", done, 0);
        check("product_hold", p, vp);
    endtask

    initial begin
        int cycles;
        int dones;

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd0,   8'd200, 16'd0};
        vecs[3] = '{8'd200, 8'd0,   16'd0};
        vecs[4] = '{8'd1,   8'd1,   16'd1};
        vecs[5] = '{8'd128, 8'd2,   16'd256};
        vecs[6] = '{8'd170, 8'd85,  16'd14450};
        vecs[7] = '{8'd255, 8'd1,   16'd255};

        clr = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_p", p, 0);
        clr = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_op(vecs[i].va, vecs[i].vb, vecs[i].vp);

        // Back-to-back with START held high; operands change during the DONE cycle.
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        step();
        cycles = 0;
        while (!done && cycles < 40) begin
            cycles++;
            step();
        end
        check("b2b_first_latency", cycles, 8);
        check("b2b_first_p", p, 15);
        a = 8'd7;
        b = 8'd9;
        step();
        check("b2b_no_bubble_busy", busy, 1);
        check("b2b_no_bubble_done", done, 0);
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin
            if (cycles == 3) check("b2b_p_hold_in_run", p, 15);
            cycles++;
            step();
        end
        check("b2b_second_latency", cycles, 8);
        check("b2b_second_p", p, 63);
        step();

        // START pulse mid-run with new operands must be ignored.
        a = 8'd6;
        b = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin
            if (cycles == 3) begin
                start = 1'b1;
                a = 8'd9;
                b = 8'd9;
            end else begin
                start = 1'b0;
            end
            cycles++;
            step();
        end
        check("ignore_latency", cycles, 8);
        check("ignore_p", p, 42);
        step();
        check("ignore_no_restart_busy", busy, 0);
        check("ignore_no_restart_done", done, 0);

        // Asynchronous clear between edges, mid-run.
        a = 8'd13;
        b = 8'd11;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("clr_pre_busy", busy, 1);
        #2;
        clr = 1'b1;
        #1;
        check("clr_async_busy", busy, 0);
        check("clr_async_done", done, 0);
        check("clr_async_p", p, 0);
        #1;
        clr = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) dones++;
        end
        check("clr_no_done", dones, 0);
        check("clr_p_stays_zero", p, 0);
        run_op(8'd13, 8'd11, 16'd143);

        // Nbit=4 instance.
        a4 = 4'd15;
        b4 = 4'd15;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        cycles = 0;
        while (!done4 && cycles < 40) begin
            cycles++;
            step();
        end
        check("n4_latency", cycles, 4);
        check("n4_product", p4, 225);
        step();
        check("n4_done_end", done4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
